// File: rtl/sim_ctrl_pkg.sv
// ============================================================================
// Module  : sim_ctrl_pkg
// Brief   : Shared types and sizing helper for the simulation-control sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sim_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        RST_LO   = 3'd1,
        RST_HI   = 3'd2,
        RELEASE  = 3'd3,
        RUN      = 3'd4,
        POLL     = 3'd5,
        WAIT_RSP = 3'd6,
        DONE     = 3'd7
    } state_e;

    // Counter width able to hold max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sim_ctrl_host_if.sv
// ============================================================================
// Module  : sim_ctrl_host_if
// Brief   : Poll-request / host-response channel between sequencer and host.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sim_ctrl_host_if #(
    parameter int EXIT_W = 32
) ();

    logic              poll_valid;
    logic              poll_ready;
    logic              rsp_valid;
    logic [EXIT_W-1:0] rsp_code;

    modport master (
        output poll_valid,
        input  poll_ready,
        input  rsp_valid,
        input  rsp_code
    );

    modport slave (
        input  poll_valid,
        output poll_ready,
        output rsp_valid,
        output rsp_code
    );

endinterface

`default_nettype wire

// File: rtl/sim_ctrl_timer.sv
// ============================================================================
// Module  : sim_ctrl_timer
// Brief   : Loadable down-counter that saturates at zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_ctrl_timer #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] value_i,
    input  wire logic             en_i,
    output logic                  zero_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= value_i;
        end else if (en_i && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero_o = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/sim_ctrl_seq.sv
// ============================================================================
// Module  : sim_ctrl_seq
// Brief   : Multi-pulse DUT reset sequencer with staggered release, periodic
//           host polling, exit-code capture, watchdog and abort.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_ctrl_seq
    import sim_ctrl_pkg::*;
#(
    parameter int NR_CHAN     = 1,
    parameter int RST_PULSES  = 2,
    parameter int RST_LO_CYC  = 10,
    parameter int RST_HI_CYC  = 10,
    parameter int STAGGER_CYC = 0,
    parameter int POLL_CYC    = 200,
    parameter int EXIT_W      = 32,
    parameter int TIMEOUT_CYC = 0
) (
    input  wire logic                clk_i,
    input  wire logic                rst_ni,
    input  wire logic                start_i,
    input  wire logic                abort_i,
    sim_ctrl_host_if.master          host,
    output logic [NR_CHAN-1:0]       dut_rst_no,
    output logic                     done_o,
    output logic                     fail_o,
    output logic                     timeout_o,
    output logic [EXIT_W-2:0]        exit_code_o,
    output logic [STATE_W-1:0]       state_o
);

    localparam int c_stg_m1 = (STAGGER_CYC > 0) ? STAGGER_CYC - 1 : 0;
    localparam int c_ph_max = (RST_LO_CYC > RST_HI_CYC)
                            ? ((RST_LO_CYC - 1 > c_stg_m1) ? RST_LO_CYC - 1 : c_stg_m1)
                            : ((RST_HI_CYC - 1 > c_stg_m1) ? RST_HI_CYC - 1 : c_stg_m1);
    localparam int c_ph_w   = cnt_w(c_ph_max);
    localparam int c_poll_w = cnt_w(POLL_CYC - 1);
    localparam int c_wd_w   = cnt_w(TIMEOUT_CYC);
    localparam int c_pc_w   = cnt_w(RST_PULSES);
    localparam int c_rel_w  = cnt_w(NR_CHAN);

    localparam logic [c_ph_w-1:0]   c_lo_load   = c_ph_w'(RST_LO_CYC - 1);
    localparam logic [c_ph_w-1:0]   c_hi_load   = c_ph_w'(RST_HI_CYC - 1);
    localparam logic [c_ph_w-1:0]   c_stg_load  = c_ph_w'(c_stg_m1);
    localparam logic [c_poll_w-1:0] c_poll_load = c_poll_w'(POLL_CYC - 1);
    localparam logic [c_wd_w-1:0]   c_wd_load   = c_wd_w'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [c_pc_w-1:0]   c_pulse_last = c_pc_w'(RST_PULSES - 1);
    localparam logic [c_rel_w-1:0]  c_rel_all   = c_rel_w'(NR_CHAN);
    // With no stagger every channel is released on the first RELEASE cycle.
    localparam logic [c_rel_w-1:0]  c_rel_first = (STAGGER_CYC == 0) ? c_rel_all : c_rel_w'(1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [c_pc_w-1:0]   r_pulse_cnt;
    logic [c_rel_w-1:0]  r_rel_cnt;
    logic                r_fail;
    logic                r_timeout;
    logic [EXIT_W-2:0]   r_exit_code;

    logic                w_ph_load, w_ph_en, w_ph_zero;
    logic [c_ph_w-1:0]   w_ph_val;
    logic                w_poll_load, w_poll_en, w_poll_zero;
    logic                w_wd_load, w_wd_en, w_wd_zero, w_wd_fire;
    logic                w_clr, w_rsp_done, w_tmo;
    logic                w_pulse_inc, w_pulse_clr, w_rel_init, w_rel_inc;
    logic                w_rst_hi_all;
    logic [EXIT_W-2:0]   w_rsp_exit;

    assign w_rsp_exit = host.rsp_code[EXIT_W-1:1];
    assign w_wd_fire  = (TIMEOUT_CYC != 0) && w_wd_zero;
    assign w_ph_en    = r_state inside {RST_LO, RST_HI, RELEASE};
    assign w_poll_en  = (r_state == RUN);
    assign w_wd_en    = r_state inside {RUN, POLL, WAIT_RSP};

    sim_ctrl_timer #(.WIDTH(c_ph_w)) u_phase_tmr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (w_ph_load),
        .value_i(w_ph_val),
        .en_i   (w_ph_en),
        .zero_o (w_ph_zero)
    );

    sim_ctrl_timer #(.WIDTH(c_poll_w)) u_poll_tmr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (w_poll_load),
        .value_i(c_poll_load),
        .en_i   (w_poll_en),
        .zero_o (w_poll_zero)
    );

    sim_ctrl_timer #(.WIDTH(c_wd_w)) u_wdog_tmr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (w_wd_load),
        .value_i(c_wd_load),
        .en_i   (w_wd_en),
        .zero_o (w_wd_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ph_load   = 1'b0;
        w_ph_val    = '0;
        w_poll_load = 1'b0;
        w_wd_load   = 1'b0;
        w_clr       = 1'b0;
        w_rsp_done  = 1'b0;
        w_tmo       = 1'b0;
        w_pulse_inc = 1'b0;
        w_pulse_clr = 1'b0;
        w_rel_init  = 1'b0;
        w_rel_inc   = 1'b0;
        if (abort_i) begin
            w_state_nxt = IDLE;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        w_state_nxt = RST_LO;
                        w_ph_load   = 1'b1;
                        w_ph_val    = c_lo_load;
                        w_pulse_clr = 1'b1;
                        w_clr       = (r_state == DONE);
                    end
                end
                RST_LO: begin
                    if (w_ph_zero) begin
                        w_ph_load = 1'b1;
                        if (r_pulse_cnt < c_pulse_last) begin
                            w_state_nxt = RST_HI;
                            w_ph_val    = c_hi_load;
                            w_pulse_inc = 1'b1;
                        end else begin
                            w_state_nxt = RELEASE;
                            w_ph_val    = c_stg_load;
                            w_rel_init  = 1'b1;
                        end
                    end
                end
                RST_HI: begin
                    if (w_ph_zero) begin
                        w_state_nxt = RST_LO;
                        w_ph_load   = 1'b1;
                        w_ph_val    = c_lo_load;
                    end
                end
                RELEASE: begin
                    if (r_rel_cnt == c_rel_all) begin
                        w_state_nxt = RUN;
                        w_poll_load = 1'b1;
                        w_wd_load   = 1'b1;
                    end else if (w_ph_zero) begin
                        w_rel_inc = 1'b1;
                        w_ph_load = 1'b1;
                        w_ph_val  = c_stg_load;
                    end
                end
                RUN: begin
                    if (w_wd_fire) begin
                        w_state_nxt = DONE;
                        w_tmo       = 1'b1;
                    end else if (w_poll_zero) begin
                        w_state_nxt = POLL;
                    end
                end
                POLL: begin
                    if (w_wd_fire) begin
                        w_state_nxt = DONE;
                        w_tmo       = 1'b1;
                    end else if (host.poll_ready) begin
                        w_state_nxt = WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // A response arriving with the watchdog expiry takes precedence.
                    if (host.rsp_valid) begin
                        if (host.rsp_code == '0) begin
                            w_state_nxt = RUN;
                            w_poll_load = 1'b1;
                        end else begin
                            w_state_nxt = DONE;
                            w_rsp_done  = 1'b1;
                        end
                    end else if (w_wd_fire) begin
                        w_state_nxt = DONE;
                        w_tmo       = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_exit_code <= '0;
            r_pulse_cnt <= '0;
            r_rel_cnt   <= '0;
        end else begin
            if (w_clr) begin
                r_fail      <= 1'b0;
                r_timeout   <= 1'b0;
                r_exit_code <= '0;
            end else if (w_rsp_done) begin
                r_exit_code <= w_rsp_exit;
                r_fail      <= |w_rsp_exit;
            end else if (w_tmo) begin
                r_timeout <= 1'b1;
                r_fail    <= 1'b1;
            end
            if (w_pulse_clr) begin
                r_pulse_cnt <= '0;
            end else if (w_pulse_inc) begin
                r_pulse_cnt <= r_pulse_cnt + c_pc_w'(1);
            end
            if (w_rel_init) begin
                r_rel_cnt <= c_rel_first;
            end else if (w_rel_inc) begin
                r_rel_cnt <= r_rel_cnt + c_rel_w'(1);
            end
        end
    end

    assign w_rst_hi_all = r_state inside {RST_HI, RUN, POLL, WAIT_RSP, DONE};

    // During RELEASE, r_rel_cnt holds how many channels are already out of reset.
    for (genvar k = 0; k < NR_CHAN; k++) begin : g_chan
        localparam logic [c_rel_w-1:0] c_k = c_rel_w'(k);
        assign dut_rst_no[k] = w_rst_hi_all || ((r_state == RELEASE) && (r_rel_cnt > c_k));
    end

    assign host.poll_valid = (r_state == POLL);
    assign done_o          = (r_state == DONE);
    assign fail_o          = r_fail;
    assign timeout_o       = r_timeout;
    assign exit_code_o     = r_exit_code;
    assign state_o         = r_state;

endmodule

`default_nettype wire

// File: tb/tb_sim_ctrl_seq.sv
// ============================================================================
// Module  : tb_sim_ctrl_seq
// Brief   : Self-checking bench for sim_ctrl_seq (default and staggered/watchdog builds).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sim_ctrl_seq;
    import sim_ctrl_pkg::*;

    localparam int LO     = 10;
    localparam int HI     = 10;
    localparam int PULSES = 2;
    localparam int POLL_T = 200;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel   = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_code  = '0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    sim_ctrl_host_if #(.EXIT_W(32)) a_host ();
    sim_ctrl_host_if #(.EXIT_W(32)) b_host ();

    assign a_host.poll_ready = ready & ~sel;
    assign a_host.rsp_valid  = rsp_valid & ~sel;
    assign a_host.rsp_code   = rsp_code;
    assign b_host.poll_ready = ready & sel;
    assign b_host.rsp_valid  = rsp_valid & sel;
    assign b_host.rsp_code   = rsp_code;

    logic [0:0]  a_rst;
    logic [2:0]  b_rst;
    logic        a_done, a_fail, a_tmo, b_done, b_fail, b_tmo;
    logic [30:0] a_exit, b_exit;
    logic [2:0]  a_state, b_state;

    sim_ctrl_seq u_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start & ~sel), .abort_i(abort & ~sel),
        .host(a_host), .dut_rst_no(a_rst), .done_o(a_done), .fail_o(a_fail),
        .timeout_o(a_tmo), .exit_code_o(a_exit), .state_o(a_state)
    );

    sim_ctrl_seq #(.NR_CHAN(3), .STAGGER_CYC(4), .TIMEOUT_CYC(500)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start & sel), .abort_i(abort & sel),
        .host(b_host), .dut_rst_no(b_rst), .done_o(b_done), .fail_o(b_fail),
        .timeout_o(b_tmo), .exit_code_o(b_exit), .state_o(b_state)
    );

    wire [2:0]  o_rst   = sel ? b_rst : {2'b00, a_rst};
    wire        o_poll  = sel ? b_host.poll_valid : a_host.poll_valid;
    wire        o_done  = sel ? b_done : a_done;
    wire        o_fail  = sel ? b_fail : a_fail;
    wire        o_tmo   = sel ? b_tmo  : a_tmo;
    wire [30:0] o_exit  = sel ? b_exit : a_exit;
    wire [2:0]  o_state = sel ? b_state : a_state;

    typedef struct {
        logic [31:0] code;
        int          rdy;
        int          rsp;
        logic [30:0] exit_v;
        logic        fail_v;
    } vec_t;

    vec_t vecs[6];

    function automatic int n_ch();
        return sel ? 3 : 1;
    endfunction

    function automatic int s_cyc();
        return sel ? 4 : 0;
    endfunction

    function automatic logic [2:0] all_on();
        return sel ? 3'b111 : 3'b001;
    endfunction

    // Expected reset vector e cycles after the start pulse was taken.
    function automatic logic [2:0] exp_rst(input int e);
        int          region;
        logic [2:0]  v;
        region = PULSES * LO + (PULSES - 1) * HI;
        v = 3'b000;
        if (e < region) begin
            if ((e % (LO + HI)) >= LO) v = all_on();
        end else begin
            for (int k = 0; k < n_ch(); k++)
                if (e - region >= k * s_cyc()) v[k] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [30:0] model_exit(input logic [31:0] code);
        logic [31:0] t;
        t = code >> 1;
        return t[30:0];
    endfunction

    function automatic logic model_fail(input logic [31:0] code);
        return (code >> 1) != 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Start from IDLE/DONE and follow the whole reset sequence up to the first poll.
    task automatic run_seq();
        int e_run, bad_rst, bad_poll, bad_st;
        bad_rst = 0; bad_poll = 0; bad_st = 0;
        start = 1'b1; tick(); start = 1'b0;
        chk("start_state", o_state, RST_LO);
        chk("start_clear", {o_done, o_fail, o_tmo, o_exit}, 64'd0);
        e_run = PULSES * LO + (PULSES - 1) * HI + (n_ch() - 1) * s_cyc() + 1;
        for (int e = 0; e <= e_run + POLL_T; e++) begin
            if (o_rst !== exp_rst(e)) bad_rst++;
            if (o_poll !== (e == e_run + POLL_T)) bad_poll++;
            if ((o_state == RUN) !== (e >= e_run && e < e_run + POLL_T)) bad_st++;
            if (e < e_run + POLL_T) tick();
        end
        chk("rst_wave", bad_rst, 0);
        chk("poll_first", bad_poll, 0);
        chk("run_window", bad_st, 0);
    endtask

    task automatic handshake(input int d);
        int bad;
        bad = 0;
        chk("poll_pre_hs", {o_poll, o_state}, {1'b1, POLL});
        for (int i = 0; i < d; i++) begin
            ready = 1'b0;
            if (o_poll !== 1'b1 || o_state != POLL) bad++;
            tick();
        end
        if (d > 0) chk("poll_hold", bad, 0);
        ready = 1'b1; tick(); ready = 1'b0;
        chk("hs_wait", {o_poll, o_state}, {1'b0, WAIT_RSP});
    endtask

    task automatic respond(input int r, input logic [31:0] code, input logic [30:0] exp_exit,
                           input logic exp_fail, input bit noise);
        int bad, gap;
        bad = 0;
        for (int i = 0; i < r; i++) begin
            if (o_state != WAIT_RSP || o_done !== 1'b0) bad++;
            start = noise && (i == 0);
            tick();
            start = 1'b0;
        end
        if (r > 0) chk("wait_idle", bad, 0);
        rsp_valid = 1'b1; rsp_code = code; tick(); rsp_valid = 1'b0; rsp_code = $urandom;
        if (code == 32'd0) begin
            chk("rsp0_run", o_state, RUN);
            gap = 0;
            while (o_poll !== 1'b1 && gap < POLL_T + 10) begin
                if (noise && gap == POLL_T / 4) begin
                    start = 1'b1; rsp_valid = 1'b1;
                end
                tick();
                start = 1'b0; rsp_valid = 1'b0;
                gap++;
            end
            chk("poll_gap", gap, POLL_T);
        end else begin
            chk("done_flags", {o_done, o_tmo, o_fail}, {1'b1, 1'b0, exp_fail});
            chk("exit_code", o_exit, exp_exit);
            chk("done_rst", o_rst, all_on());
            for (int i = 0; i < 3; i++) begin
                rsp_valid = 1'b1; rsp_code = $urandom | 32'd1;
                tick();
                rsp_valid = 1'b0;
                if (o_exit !== exp_exit || o_done !== 1'b1 || o_poll !== 1'b0) bad++;
            end
            chk("done_hold", bad, 0);
        end
    endtask

    initial begin
        int          t, d, r;
        logic [31:0] code;

        vecs[0] = '{32'h0000_0000, 2, 3, 31'h0,         1'b0};
        vecs[1] = '{32'h0000_000B, 0, 1, 31'h5,         1'b1};
        vecs[2] = '{32'h0000_0001, 5, 0, 31'h0,         1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 1, 2, 31'h7FFF_FFFF, 1'b1};
        vecs[4] = '{32'h8000_0000, 3, 0, 31'h4000_0000, 1'b1};
        vecs[5] = '{32'h0000_0002, 0, 4, 31'h1,         1'b1};

        repeat (3) tick();
        chk("reset_a_outs", {o_rst, o_poll, o_done, o_fail, o_tmo, o_exit}, 64'd0);
        chk("reset_a_state", o_state, IDLE);
        sel = 1'b1; #1;
        chk("reset_b_outs", {o_rst, o_poll, o_done, o_fail, o_tmo, o_exit}, 64'd0);
        sel = 1'b0; #1;
        rst_n = 1'b1;
        tick();

        // Default build: first sequence, held poll, code-0 round trip.
        run_seq();
        handshake(5);
        respond(4, 32'd0, 31'd0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            handshake(vecs[i].rdy);
            respond(vecs[i].rsp, vecs[i].code, vecs[i].exit_v, vecs[i].fail_v, 1'b0);
            if (vecs[i].code != 32'd0) run_seq();
        end

        for (int i = 0; i < 12; i++) begin
            d    = $urandom_range(0, 6);
            r    = $urandom_range(0, 8);
            code = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
            handshake(d);
            respond(r, code, model_exit(code), model_fail(code), 1'b1);
            if (code != 32'd0) run_seq();
        end

        // Staggered three-channel build with watchdog.
        sel = 1'b1; #1;
        run_seq();
        handshake(2);
        respond(3, 32'h0000_000B, 31'd5, 1'b1, 1'b0);

        run_seq();
        handshake(0);
        t = POLL_T + 1;
        while (o_done !== 1'b1 && t < 700) begin
            tick();
            t++;
        end
        chk("wd_cycle", t, 500);
        chk("wd_flags", {o_done, o_tmo, o_fail}, 3'b111);
        chk("wd_exit", o_exit, 31'd0);

        run_seq();
        handshake(1);
        repeat (4) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_state", o_state, IDLE);
        chk("abort_outs", {o_rst, o_poll, o_done, o_fail, o_tmo, o_exit}, 64'd0);
        run_seq();

        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {o_state, o_rst, o_poll}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
